// File: rtl/ip_msxbus_bridge.sv
// ============================================================================
// ip_msxbus_bridge
// ----------------------------------------------------------------------------
// Bridges MSX cartridge-slot I/O cycles onto the internal req/ack register bus
// of the VDP. Each qualified CPU strobe becomes exactly one req/ack
// transaction. The CPU is held with twait until the VDP answers or the wait
// times out. On reads the returned byte (0xFF after a timeout) is driven onto
// td until the CPU ends the cycle.
//
// Ports
//   clk, n_reset        108 MHz clock, synchronous active-low reset
//   n_ce, n_trd, n_twr  slot chip enable / read / write strobes (active-low)
//   ta[1:0], td_in[7:0] slot address and data-bus input
//   td_out, td_oe, tdir data-bus drive value, drive enable, level-shifter dir
//   twait               1 = hold the CPU (inverted to /WAIT on the board)
//   req, ack            internal request / one-clock acknowledge
//   wr, address, wdata  internal transaction attributes, stable while req=1
//   rdata               internal read data, valid in the ack cycle
//   timeout_flag        one-clock pulse when a transaction is aborted
// ============================================================================
module ip_msxbus_bridge #(
    parameter int unsigned QUALIFY = 2,    // 1..7 consecutive synced samples
    parameter int unsigned TIMEOUT = 255   // 1..255 clocks to wait for ack
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       n_ce,
    input  logic       n_trd,
    input  logic       n_twr,
    input  logic [1:0] ta,
    input  logic [7:0] td_in,
    output logic [7:0] td_out,
    output logic       td_oe,
    output logic       tdir,
    output logic       twait,
    output logic       req,
    input  logic       ack,
    output logic       wr,
    output logic [1:0] address,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RD_HOLD = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [2:0] QUAL_MAX = 3'(QUALIFY);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Two-stage synchronizer for every slot input.
    // Packing: {td_in, ta, n_twr, n_trd, n_ce}. Reset loads all ones so the
    // strobes look inactive straight after reset.
    // ------------------------------------------------------------------------
    logic [12:0] sync1, sync2;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples the pre-edge value of its source.
        if (!n_reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {td_in, ta, n_twr, n_trd, n_ce};
            sync2 <= sync1;
        end
    end

    logic       s_ce, s_trd, s_twr;
    logic [1:0] s_ta;
    logic [7:0] s_td;

    assign s_ce  = sync2[0];
    assign s_trd = sync2[1];
    assign s_twr = sync2[2];
    assign s_ta  = sync2[4:3];
    assign s_td  = sync2[12:5];

    // A legal pattern is chip enable low with exactly one strobe low.
    logic pattern_ok, pattern_wr;

    assign pattern_ok = !s_ce && (s_trd ^ s_twr);
    assign pattern_wr = !s_twr;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t     state, state_n;
    logic [2:0] qual_cnt, qual_cnt_n;
    logic       qual_wr, qual_wr_n;
    logic [7:0] tcnt, tcnt_n;
    logic       req_n, wr_n, td_oe_n, twait_n, tflag_n;
    logic [1:0] address_n;
    logic [7:0] wdata_n, td_out_n;
    logic       qualified;

    // The count is registered, so qualification is seen one clock after the
    // QUALIFY-th matching sample: req rises 2 + QUALIFY + 1 clocks after the pin.
    assign qualified = (qual_cnt == QUAL_MAX);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            qual_cnt     <= '0;
            qual_wr      <= 1'b0;
            tcnt         <= '0;
            req          <= 1'b0;
            wr           <= 1'b0;
            address      <= '0;
            wdata        <= '0;
            td_out       <= '0;
            td_oe        <= 1'b0;
            twait        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_n;
            qual_cnt     <= qual_cnt_n;
            qual_wr      <= qual_wr_n;
            tcnt         <= tcnt_n;
            req          <= req_n;
            wr           <= wr_n;
            address      <= address_n;
            wdata        <= wdata_n;
            td_out       <= td_out_n;
            td_oe        <= td_oe_n;
            twait        <= twait_n;
            timeout_flag <= tflag_n;
        end
    end

    assign tdir = td_oe;

    // ------------------------------------------------------------------------
    // Qualification counter, next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_n    = state;
        qual_cnt_n = qual_cnt;
        qual_wr_n  = qual_wr;
        tcnt_n     = tcnt;
        req_n      = req;
        wr_n       = wr;
        address_n  = address;
        wdata_n    = wdata;
        td_out_n   = td_out;
        td_oe_n    = td_oe;
        twait_n    = twait;
        tflag_n    = 1'b0;

        // Count consecutive samples of the same legal pattern; a change of
        // direction restarts the count, an illegal pattern clears it.
        if (!pattern_ok) begin
            qual_cnt_n = '0;
        end else if (qual_cnt == '0 || pattern_wr != qual_wr) begin
            qual_cnt_n = 3'd1;
            qual_wr_n  = pattern_wr;
        end else if (qual_cnt < QUAL_MAX) begin
            qual_cnt_n = qual_cnt + 3'd1;
        end

        case (state)
            S_IDLE: begin
                if (qualified) begin
                    address_n = s_ta;
                    wr_n      = qual_wr;
                    if (qual_wr) begin
                        wdata_n = s_td;
                    end
                    req_n   = 1'b1;
                    twait_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = S_REQ;
                end
            end

            S_REQ: begin
                // ack is tested first so it wins over a simultaneous timeout.
                if (ack) begin
                    req_n = 1'b0;
                    if (wr) begin
                        twait_n = 1'b0;
                        state_n = S_END;
                    end else begin
                        td_out_n = rdata;
                        td_oe_n  = 1'b1;
                        state_n  = S_RD_HOLD;
                    end
                end else if (tcnt == TO_LAST) begin
                    req_n   = 1'b0;
                    twait_n = 1'b0;
                    tflag_n = 1'b1;
                    if (wr) begin
                        state_n = S_END;
                    end else begin
                        td_out_n = 8'hFF;
                        td_oe_n  = 1'b1;
                        state_n  = S_RD_HOLD;
                    end
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end

            S_RD_HOLD: begin
                twait_n = 1'b0;
                if (s_trd || s_ce) begin
                    td_oe_n = 1'b0;
                    state_n = S_IDLE;
                end
            end

            S_END: begin
                // Wait for the strobe to end so one long strobe cannot start
                // a second transaction.
                if (s_twr || s_ce) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ip_msxbus_bridge.sv
// ============================================================================
// tb_ip_msxbus_bridge
// ----------------------------------------------------------------------------
// Self-checking bench for ip_msxbus_bridge. The bench plays both the MSX CPU
// (slot strobes) and the VDP (ack/rdata). Expected behaviour of each CPU
// cycle is computed from the bridge's transaction rules: fixed request
// latency, request length min(ack delay + 1, TIMEOUT), returned byte or 0xFF,
// one timeout pulse per abort, and exactly one req per CPU cycle.
// ============================================================================
module tb_ip_msxbus_bridge;

    localparam int QUALIFY = 2;
    localparam int TIMEOUT = 16;
    localparam int REQ_LAT = 2 + QUALIFY + 1;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       n_ce, n_trd, n_twr;
    logic [1:0] ta;
    logic [7:0] td_in;
    logic [7:0] td_out;
    logic       td_oe, tdir, twait, req, ack, wr, timeout_flag;
    logic [1:0] address;
    logic [7:0] wdata, rdata;

    ip_msxbus_bridge #(
        .QUALIFY(QUALIFY),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .n_ce        (n_ce),
        .n_trd       (n_trd),
        .n_twr       (n_twr),
        .ta          (ta),
        .td_in       (td_in),
        .td_out      (td_out),
        .td_oe       (td_oe),
        .tdir        (tdir),
        .twait       (twait),
        .req         (req),
        .ack         (ack),
        .wr          (wr),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: outcome of one CPU cycle from the transaction rules.
    // ------------------------------------------------------------------------
    typedef struct {
        bit       timed_out;
        int       req_len;
        logic [7:0] rd_byte;
    } outcome_t;

    function automatic outcome_t model(input int ack_k, input logic [7:0] rd);
        outcome_t o;
        // ack presented k clocks after req is seen arrives in the (k+1)-th
        // clock of the request; it must come by clock TIMEOUT to win.
        o.timed_out = (ack_k + 1 > TIMEOUT);
        o.req_len   = o.timed_out ? TIMEOUT : ack_k + 1;
        o.rd_byte   = o.timed_out ? 8'hFF : rd;
        return o;
    endfunction

    // Monitors of req rising edges and timeout pulses, sampled mid-cycle.
    int   req_rises = 0;
    int   tflags    = 0;
    int   exp_rises = 0;
    int   exp_tflags = 0;
    logic req_q = 1'b0;

    always @(negedge clk) begin
        if (req === 1'b1 && req_q !== 1'b1) req_rises++;
        if (timeout_flag === 1'b1) tflags++;
        req_q = req;
    end

    // ------------------------------------------------------------------------
    // Wait for the request raised by already-driven pins, answer it, and check
    // the transaction. Called and returns on a falling clock edge.
    // ------------------------------------------------------------------------
    task automatic serve(input bit is_wr, input logic [1:0] a, input logic [7:0] d,
                         input int ack_k, input logic [7:0] rd);
        outcome_t o;
        int lat;
        int cnt;
        o   = model(ack_k, rd);
        lat = 0;
        while (req !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("req_latency", 32'(lat), 32'(REQ_LAT));
        if (req !== 1'b1) return;
        exp_rises++;
        check("req_wr", 32'(wr), 32'(is_wr));
        check("req_address", 32'(address), 32'(a));
        if (is_wr) check("req_wdata", 32'(wdata), 32'(d));
        check("twait_in_req", 32'(twait), 32'd1);
        check("td_oe_in_req", 32'(td_oe), 32'd0);

        cnt = 0;
        while (req === 1'b1 && cnt < TIMEOUT + 8) begin
            if (!o.timed_out && cnt == ack_k) begin
                ack   = 1'b1;
                rdata = rd;
            end
            @(negedge clk);
            ack   = 1'b0;
            rdata = 8'($urandom);
            cnt++;
        end
        check("req_length", 32'(cnt), 32'(o.req_len));
        check("timeout_flag", 32'(timeout_flag), 32'(o.timed_out));
        if (o.timed_out) exp_tflags++;
        if (is_wr || o.timed_out) check("twait_released", 32'(twait), 32'd0);
        if (!is_wr) begin
            check("rd_td_oe", 32'(td_oe), 32'd1);
            check("rd_tdir", 32'(tdir), 32'd1);
            check("rd_td_out", 32'(td_out), 32'(o.rd_byte));
        end
        @(negedge clk);
        check("timeout_single", 32'(timeout_flag), 32'd0);
        check("twait_low", 32'(twait), 32'd0);
        check("req_low", 32'(req), 32'd0);
    endtask

    task automatic drive_cycle(input bit is_wr, input logic [1:0] a, input logic [7:0] d);
        n_ce  = 1'b0;
        ta    = a;
        td_in = d;
        n_twr = !is_wr;
        n_trd = is_wr;
    endtask

    // Release the strobes; a read must keep driving td for exactly 3 clocks.
    task automatic release_pins(input bit is_wr);
        n_ce  = 1'b1;
        n_trd = 1'b1;
        n_twr = 1'b1;
        if (!is_wr) begin
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                check((i < 3) ? "td_oe_tail" : "td_oe_off", 32'(td_oe), (i < 3) ? 32'd1 : 32'd0);
            end
        end
    endtask

    // One full CPU cycle: drive, serve, hold the strobe (with stray acks that
    // must be ignored), release, then idle for gap clocks.
    task automatic run_cycle(input bit is_wr, input logic [1:0] a, input logic [7:0] d,
                             input int ack_k, input logic [7:0] rd, input int hold, input int gap);
        outcome_t o;
        o = model(ack_k, rd);
        drive_cycle(is_wr, a, d);
        serve(is_wr, a, d, ack_k, rd);
        for (int i = 0; i < hold; i++) begin
            ack = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            ack = 1'b0;
        end
        check("no_duplicate_req", 32'(req_rises), 32'(exp_rises));
        if (!is_wr) check("rd_td_out_held", 32'(td_out), 32'(o.rd_byte));
        release_pins(is_wr);
        repeat (gap) @(negedge clk);
        check("idle_req", 32'(req), 32'd0);
        check("idle_td_oe", 32'(td_oe), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_td_out"}, 32'(td_out), 32'd0);
        check({tag, "_td_oe"}, 32'(td_oe), 32'd0);
        check({tag, "_tdir"}, 32'(tdir), 32'd0);
        check({tag, "_twait"}, 32'(twait), 32'd0);
        check({tag, "_req"}, 32'(req), 32'd0);
        check({tag, "_wr"}, 32'(wr), 32'd0);
        check({tag, "_address"}, 32'(address), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0;
        n_ce    = 1'b1;
        n_trd   = 1'b1;
        n_twr   = 1'b1;
        ta      = 2'b00;
        td_in   = 8'h00;
        ack     = 1'b0;
        rdata   = 8'h00;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset_req", 32'(req), 32'd0);

        // Write: ack 3 clocks after req.
        run_cycle(1'b1, 2'b01, 8'h8E, 2, 8'h00, 12, 4);
        // Read: ack with 0x5A 6 clocks after req.
        run_cycle(1'b0, 2'b00, 8'h00, 5, 8'h5A, 2, 4);
        // Read with no ack: timeout, 0xFF returned.
        run_cycle(1'b0, 2'b11, 8'h00, TIMEOUT + 3, 8'h77, 2, 4);
        // ack in the same clock the timeout would fire: ack wins.
        run_cycle(1'b0, 2'b10, 8'h00, TIMEOUT - 1, 8'hA5, 1, 4);
        // Write timeout, then a normal cycle.
        run_cycle(1'b1, 2'b10, 8'h3C, TIMEOUT, 8'h00, 3, 4);
        run_cycle(1'b0, 2'b01, 8'h00, 0, 8'hC7, 0, 4);

        // One-clock read glitch: no request.
        n_ce  = 1'b0;
        n_trd = 1'b0;
        @(negedge clk);
        n_ce  = 1'b1;
        n_trd = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_no_req", 32'(req_rises), 32'(exp_rises));
        check("glitch_td_oe", 32'(td_oe), 32'd0);

        // Both strobes low together: illegal, no request, td never driven.
        n_ce  = 1'b0;
        n_trd = 1'b0;
        n_twr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("both_td_oe", 32'(td_oe), 32'd0);
        end
        check("both_no_req", 32'(req_rises), 32'(exp_rises));
        n_ce  = 1'b1;
        n_trd = 1'b1;
        n_twr = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during RD_HOLD with the strobe held, then exactly one new cycle.
        drive_cycle(1'b0, 2'b10, 8'h00);
        serve(1'b0, 2'b10, 8'h00, 1, 8'hC3);
        n_reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        n_reset = 1'b1;
        serve(1'b0, 2'b10, 8'h00, 2, 8'h3C);
        repeat (6) @(negedge clk);
        check("post_reset_single_req", 32'(req_rises), 32'(exp_rises));
        release_pins(1'b0);
        repeat (4) @(negedge clk);

        // Back-to-back writes separated by 4 clocks, early ack with long hold.
        run_cycle(1'b1, 2'b00, 8'h11, 0, 8'h00, 15, 4);
        run_cycle(1'b1, 2'b11, 8'hEE, 0, 8'h00, 15, 4);

        // Randomized cycles.
        for (int n = 0; n < 40; n++) begin
            bit         is_wr;
            int         ack_k;
            is_wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) ack_k = $urandom_range(TIMEOUT - 1, TIMEOUT + 4);
            else                           ack_k = $urandom_range(0, TIMEOUT - 2);
            run_cycle(is_wr, 2'($urandom), 8'($urandom), ack_k, 8'($urandom),
                      $urandom_range(0, 6), $urandom_range(4, 8));
        end

        check("total_req_count", 32'(req_rises), 32'(exp_rises));
        check("total_timeouts", 32'(tflags), 32'(exp_tflags));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_msxbus_bridge.md
Name: ip_msxbus_bridge

Overview:
- Responder on the MSX cartridge slot bus (n_ce, n_trd, n_twr, ta, td, tdir, twait); initiator on the internal req/ack register bus that ip_debugger drives today.
- Converts each MSX CPU I/O cycle into one req/ack transaction toward the VDP, holding the CPU with twait until the VDP answers.
- On reads, drives the returned byte onto td until the CPU ends the cycle.
- Sits in tang20cart_msx between the cartridge pins and the VDP REQ/ACK/WRT/ADR/DBO/DBI ports, and replaces ip_debugger as the bus master.

Parameters:
- QUALIFY, 2: consecutive synchronized samples a strobe pattern must hold before a cycle is accepted (1..7).
- TIMEOUT, 255: clocks to wait for ack before aborting (1..255; 8-bit counter).

Ports:
- clk  in  1  system clock, 108 MHz
- n_reset  in  1  synchronous reset, active-low
- n_ce  in  1  cartridge chip enable from slot, active-low
- n_trd  in  1  read strobe, active-low
- n_twr  in  1  write strobe, active-low
- ta  in  2  CPU address bits [1:0]
- td_in  in  8  data bus input
- td_out  out  8  data bus output value
- td_oe  out  1  1 = FPGA drives td
- tdir  out  1  level-shifter direction, 1 = cartridge to MSX; always equals td_oe
- twait  out  1  1 = hold CPU (board inverts to /WAIT)
- req  out  1  internal request
- ack  in  1  internal acknowledge, one-clock pulse
- wr  out  1  1 = write, 0 = read; valid while req=1
- address  out  2  latched ta
- wdata  out  8  latched write data
- rdata  in  8  read data; valid in the ack cycle
- timeout_flag  out  1  one-clock pulse when a transaction aborts

Behaviour:
- Reset: when n_reset=0 at a clk edge, all outputs go to 0 on that edge: td_out=0x00, td_oe=0, tdir=0, twait=0, req=0, wr=0, address=0, wdata=0x00, timeout_flag=0. State returns to IDLE and the synchronizers load 1s (strobes inactive). This applies mid-transaction.
- Input sync: n_ce, n_trd, n_twr, ta and td_in each pass a 2-FF synchronizer. All decisions use synchronized values.
- A cycle is qualified when synced n_ce=0 and exactly one of synced n_trd/n_twr is 0 for QUALIFY consecutive clocks. If both strobes are 0, nothing is qualified and the state stays IDLE.

State machine:
- IDLE: on qualification, latch address←ta and wr←(n_twr==0). If writing, also latch wdata←td_in. Next state is REQ. req=1 and twait=1 take effect on the next edge.
- Latency: req rises 2 (sync) + QUALIFY + 1 clocks after the pin edge, which is 5 clocks (46 ns) at the default QUALIFY. This is well inside the Z80 WAIT sample window.
- REQ: hold req, wr, address, wdata stable and increment the timeout counter.
  - On ack=1: req←0. For a read, td_out←rdata and td_oe←1; next state is RD_HOLD. For a write, twait←0; next state is END.
  - If the counter reaches TIMEOUT with no ack: req←0, twait←0, timeout_flag pulses for one clock. For a read, td_out←0xFF and td_oe←1; next state is RD_HOLD. For a write, next state is END.
  - If ack arrives in the same clock as the counter reaches TIMEOUT, ack wins and there is no timeout_flag.
- RD_HOLD: twait←0 and keep driving td. When synced n_trd=1 or n_ce=1: td_oe←0 and next state is IDLE.
- END: wait for synced n_ce=1 or n_twr=1, then go to IDLE. This prevents one long strobe from producing a second transaction.
- ack outside REQ is ignored.
- req never rises again within 1 clock of falling; each MSX cycle produces exactly one req.
- If the CPU drops its strobe while in REQ (protocol violation), complete the internal transaction normally, then pass straight through RD_HOLD or END to IDLE.

Test Plan:
- Write: n_ce=0, n_twr=0, ta=2'b01, td=0x8E held 20 clocks, ack returned 3 clocks after req → exactly one req with wr=1, address=1, wdata=0x8E; twait high from the req edge until the clock after ack; back in IDLE after strobes release.
- Read: ta=2'b00, n_trd=0; ack with rdata=0x5A 6 clocks after req → td_out=0x5A with td_oe=tdir=1 from the clock after ack until 3 clocks after n_trd rises; twait=0 once data is driven.
- Timeout: read with ack never asserted, TIMEOUT=16 → req drops after 16 clocks, timeout_flag pulses once, td_out=0xFF; a later cycle proceeds normally.
- Glitch/illegal inputs: n_trd low for 1 clock only → no req. n_trd and n_twr low together for 10 clocks → no req, td_oe stays 0.
- Reset mid-read: n_reset=0 during RD_HOLD → next edge gives td_oe=0, twait=0, req=0, IDLE; a held strobe after reset release gives exactly one new transaction.
- Back-to-back: two writes separated by 4 clocks of strobe high → two distinct req pulses in order with correct wdata; a held strobe with early ack → no duplicate req.
